// File: rtl/button_bank.sv
// button_bank: multi-channel button conditioning.
// Per channel: optional polarity inversion, two-flop synchroniser, debounced
// level, single-cycle press/release pulses and a single-cycle long-press pulse.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-low reset
//   btn_in      in   [NUM_BTNS] raw asynchronous button pads
//   btn_level   out  [NUM_BTNS] debounced pressed state (1 = pressed)
//   btn_press   out  [NUM_BTNS] one-cycle pulse on btn_level rise
//   btn_release out  [NUM_BTNS] one-cycle pulse on btn_level fall
//   btn_long    out  [NUM_BTNS] one-cycle pulse after LONG_CYCLES of held press
module button_bank #(
  parameter int unsigned          CLK_FREQ      = 25_000_000,
  parameter int unsigned          NUM_BTNS      = 4,
  parameter int unsigned          DEBOUNCE_MS   = 10,
  parameter int unsigned          LONG_PRESS_MS = 1000,
  parameter logic [NUM_BTNS-1:0]  INVERT        = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_long
);

  localparam int unsigned DEB_CYCLES  = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LONG_CYCLES = CLK_FREQ / 1000 * LONG_PRESS_MS;
  localparam int unsigned DW          = $clog2(DEB_CYCLES + 1);
  localparam int unsigned LW          = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [NUM_BTNS-1:0] sync1_q,   sync1_d;
  logic [NUM_BTNS-1:0] sync2_q,   sync2_d;
  logic [NUM_BTNS-1:0] level_q,   level_d;
  logic [NUM_BTNS-1:0] press_q,   press_d;
  logic [NUM_BTNS-1:0] release_q, release_d;
  logic [NUM_BTNS-1:0] long_q,    long_d;
  logic [NUM_BTNS-1:0] done_q,    done_d;
  logic [DW-1:0]       deb_cnt_q  [NUM_BTNS];
  logic [DW-1:0]       deb_cnt_d  [NUM_BTNS];
  logic [LW-1:0]       hold_cnt_q [NUM_BTNS];
  logic [LW-1:0]       hold_cnt_d [NUM_BTNS];

  always_comb begin
    // Inversion happens before synchronisation so every channel is active-high
    // from the first flop onward.
    sync1_d    = btn_in ^ INVERT;
    sync2_d    = sync1_q;
    level_d    = level_q;
    press_d    = '0;
    release_d  = '0;
    long_d     = '0;
    done_d     = done_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;

    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      // Debounce: any sample agreeing with the current level restarts the count.
      if (sync2_q[i] == level_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        level_d[i]   = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end

      press_d[i]   =  level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] &  level_q[i];

      // Hold timer runs only while the level is high both before and after
      // this edge, so a release edge can never coincide with a long pulse.
      if (!(level_q[i] && level_d[i])) begin
        hold_cnt_d[i] = '0;
        done_d[i]     = 1'b0;
      end else if (!done_q[i]) begin
        if (hold_cnt_q[i] == LONG_LAST) begin
          long_d[i] = 1'b1;
          done_d[i] = 1'b1;
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      long_q     <= '0;
      done_q     <= '0;
      deb_cnt_q  <= '{default: '0};
      hold_cnt_q <= '{default: '0};
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      done_q     <= done_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_button_bank.sv
// Testbench for button_bank with CLK_FREQ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=20,
// NUM_BTNS=4, INVERT=4'b1000. Reference model tracks, per channel, the run
// length of the synchronised sample and the age of the current press.
module tb_button_bank;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam logic [3:0] INV = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;
  logic [15:0] dut_vec;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit [3:0] m_s1, m_s2, m_last, m_level, m_press, m_rel, m_long;
  int       m_run [4];
  int       m_age [4];

  button_bank #(
    .CLK_FREQ      (1000),
    .NUM_BTNS      (4),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (20),
    .INVERT        (INV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  assign dut_vec = {btn_level, btn_press, btn_release, btn_long};

  function automatic logic [15:0] exp_vec();
    return {m_level, m_press, m_rel, m_long};
  endfunction

  // Advance one clock edge, update the model from the pre-edge inputs, and
  // return at the following falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_level = '0;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int c = 0; c < 4; c++) begin
        m_run[c] = 0;
        m_age[c] = 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        bit s, old, nl;
        s   = m_s2[c];
        old = m_level[c];
        if (s == m_last[c]) m_run[c]++;
        else                m_run[c] = 1;
        m_last[c] = s;
        nl = (s != old && m_run[c] >= DEB) ? s : old;
        m_press[c] = nl & ~old;
        m_rel[c]   = ~nl & old;
        m_long[c]  = 1'b0;
        if (nl && old) begin
          m_age[c]++;
          m_long[c] = (m_age[c] == LONG);
        end else begin
          m_age[c] = 0;
        end
        m_level[c] = nl;
      end
      m_s2 = m_s1;
      m_s1 = btn_in ^ INV;
    end
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_in = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (dut_vec !== 16'h0) begin
        failures++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, dut_vec, 16'h0);
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL reset_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      checks++;
      if (btn_level !== ((k >= 6) ? 4'b0111 : 4'b0000)) begin
        failures++;
        $display("FAIL reset_level k=%0d got=%b exp=%b", k, btn_level, (k >= 6) ? 4'b0111 : 4'b0000);
      end
      checks++;
      if (btn_press !== ((k == 6) ? 4'b0111 : 4'b0000)) begin
        failures++;
        $display("FAIL reset_press k=%0d got=%b exp=%b", k, btn_press, (k == 6) ? 4'b0111 : 4'b0000);
      end
    end
    btn_in = 4'b1000;
    settle(12);
  endtask

  task automatic test_clean_ch0();
    btn_in = 4'b1001;
    for (int k = 1; k <= 18; k++) begin
      if (k == 11) btn_in[0] = 1'b0;
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL clean_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
      checks++;
      if ({btn_level[0], btn_press[0], btn_release[0], btn_long[0]} !==
          {(k >= 6 && k < 16), (k == 6), (k == 16), 1'b0}) begin
        failures++;
        $display("FAIL clean_ch0 k=%0d got=%b exp=%b", k,
                 {btn_level[0], btn_press[0], btn_release[0], btn_long[0]},
                 {(k >= 6 && k < 16), (k == 6), (k == 16), 1'b0});
      end
    end
    settle(4);
  endtask

  task automatic test_bounce_ch1();
    int t, seg;
    bit v;
    btn_in = 4'b1000;
    t = 0;
    v = 1'b1;
    while (t < 20) begin
      btn_in[1] = v;
      seg = $urandom_range(1, 3);
      for (int j = 0; j < seg; j++) begin
        step();
        checks++;
        if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || dut_vec !== exp_vec()) begin
          failures++;
          $display("FAIL bounce_quiet t=%0d got=%h exp=%h", t, dut_vec, exp_vec());
        end
      end
      t += seg;
      v = ~v;
    end
    btn_in[1] = 1'b0;
    step();
    btn_in[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (btn_press[1] !== (k == 6) || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL bounce_press k=%0d got=%h exp=%h press_exp=%0d", k, dut_vec, exp_vec(), (k == 6));
      end
    end
    // Short glitch while pressed must not release.
    btn_in[1] = 1'b0;
    settle($urandom_range(1, 3));
    btn_in[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (btn_release[1] !== 1'b0 || btn_level[1] !== 1'b1 || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL glitch_hold k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    btn_in[1] = 1'b0;
    settle(12);
  endtask

  task automatic test_long_ch2();
    int rel_cnt;
    btn_in = 4'b1100;
    for (int k = 1; k <= 60; k++) begin
      step();
      checks++;
      if (btn_press[2] !== (k == 6) || btn_long[2] !== (k == 26) || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL long_hold k=%0d got=%h exp=%h long_exp=%0d", k, dut_vec, exp_vec(), (k == 26));
      end
    end
    btn_in[2] = 1'b0;
    rel_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (btn_release[2] === 1'b1) rel_cnt++;
      checks++;
      if (btn_long[2] !== 1'b0 || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL long_release k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    checks++;
    if (rel_cnt !== 1) begin
      failures++;
      $display("FAIL long_release_count got=%0d exp=1", rel_cnt);
    end
  endtask

  task automatic test_simultaneous();
    btn_in = 4'b0101;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (btn_press !== ((k == 6) ? 4'b1101 : 4'b0000) || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL simul_press k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    btn_in = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (btn_release !== ((k == 6) ? 4'b1101 : 4'b0000) || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL simul_release k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midpress();
    btn_in = 4'b1001;
    settle(8);
    checks++;
    if (btn_level[0] !== 1'b1) begin
      failures++;
      $display("FAIL midpress_level got=%b exp=1", btn_level[0]);
    end
    rst = 1'b0;
    step();
    checks++;
    if (dut_vec !== 16'h0) begin
      failures++;
      $display("FAIL midpress_reset got=%h exp=%h", dut_vec, 16'h0);
    end
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (btn_press[0] !== (k == 6) || btn_release[0] !== 1'b0 ||
          btn_level[0] !== (k >= 6) || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL midpress_repress k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
      end
    end
    btn_in = 4'b1000;
    settle(10);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 11) == 0) btn_in[c] = ~btn_in[c];
      rst = ($urandom_range(0, 799) != 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random n=%0d got=%h exp=%h", n, dut_vec, exp_vec());
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    btn_in = 4'hF;
    test_reset();
    test_clean_ch0();
    test_bounce_ch1();
    test_long_ch2();
    test_simultaneous();
    test_reset_midpress();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_bank.md
# button_bank

Multi-channel button conditioning block: a parametrised successor to the single-channel debouncer used on the 25 MHz pixel-clock domain. For each of NUM_BTNS raw pad inputs it provides:
- a two-flop synchroniser;
- a debounced level;
- single-cycle press and release pulses;
- a single-cycle long-press pulse.

It sits between the board buttons and the VGA control and test logic, replacing per-button debouncer instances.

## Interface
Parameters:
- CLK_FREQ, 25_000_000, clock frequency in Hz; must be a multiple of 1000
- NUM_BTNS, 4, number of channels (1..16)
- DEBOUNCE_MS, 10, stable time required before a level change; DEB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS, must be ≥ 1
- LONG_PRESS_MS, 1000, hold time for long-press; LONG_CYCLES = CLK_FREQ/1000*LONG_PRESS_MS, must be > DEB_CYCLES
- INVERT, {NUM_BTNS{1'b0}}, per-channel mask; bit i = 1 means channel i is an active-low button, inverted before the synchroniser

Ports:
- clk  input  1  system clock, rising-edge; all logic uses this single clock
- rst  input  1  synchronous, active-low reset
- btn_in  input  NUM_BTNS  raw asynchronous button pads
- btn_level  output  NUM_BTNS  debounced pressed state, 1 = pressed
- btn_press  output  NUM_BTNS  one-cycle pulse when btn_level rises
- btn_release  output  NUM_BTNS  one-cycle pulse when btn_level falls
- btn_long  output  NUM_BTNS  one-cycle pulse after LONG_CYCLES of continuous debounced press

## Operation
- Per channel i: p = btn_in[i] ^ INVERT[i] → sync1 → sync2 (= s).
- Debounce counter width: $clog2(DEB_CYCLES+1). Per clock edge:
  - if s == btn_level[i]: cnt <= 0.
  - else if cnt == DEB_CYCLES-1: btn_level[i] <= s, cnt <= 0.
  - else: cnt <= cnt+1.
- Any sample of s equal to the current level clears cnt; a glitch shorter than DEB_CYCLES never changes btn_level.
- btn_press and btn_release are registered and assert on the same edge at which btn_level changes. Both are high for exactly one cycle and are never high together on one channel.
- Long-press:
  - Hold counter width: $clog2(LONG_CYCLES+1), plus a done flag.
  - Counter and done are cleared while btn_level == 0.
  - While btn_level == 1 and !done, the counter increments.
  - When the counter reaches LONG_CYCLES-1, btn_long pulses and done is set.
  - Once done is set, the counter stops (saturates). At most one btn_long per press; no auto-repeat.
- Release before LONG_CYCLES: no btn_long, and the counter clears.
- Channels are fully independent; simultaneous events on different channels are all reported on the same cycle.
- Reset (rst == 0 on an edge) clears every flop:
  - sync1 and sync2 go to 0, meaning released after inversion;
  - the debounce counter, hold counter and done flag go to 0;
  - all outputs go to 0.
- Reset mid-press: no release pulse is generated. After rst returns high, a button still held is re-detected as a new press after DEB_CYCLES+2 edges.

## Timing
- Reset values: btn_level, btn_press, btn_release and btn_long are all 0. They are valid on the first edge after rst is sampled low.
- Press/release latency: a clean input change arrives before edge 1. btn_level and the pulse are high after edge DEB_CYCLES+2: 2 synchroniser edges plus DEB_CYCLES counting edges.
- Long-press latency: btn_long is high after edge L+LONG_CYCLES, where btn_level rose after edge L. Equivalently, it is high after edge DEB_CYCLES+2+LONG_CYCLES from a clean press.
- Release and long-press on the same edge cannot occur: the hold counter only advances while btn_level == 1.
- All outputs are registered; there is no combinational path from btn_in.

## Test plan
Bench parameters for all scenarios:
- CLK_FREQ = 1000, DEBOUNCE_MS = 4 (DEB_CYCLES = 4), LONG_PRESS_MS = 20 (LONG_CYCLES = 20);
- NUM_BTNS = 4, INVERT = 4'b1000.

Scenarios:
- Reset: hold rst = 0 for 3 cycles with btn_in = 4'b1111 → all outputs 0. Release rst → btn_level = 4'b0111 after 6 edges, with btn_press = 4'b0111 for one cycle; channel 3 is inverted and therefore reads released.
- Clean press/release on ch0: raise btn_in[0] → btn_press[0] and btn_level[0] high after edge 6. Drop it after 10 cycles → btn_release[0] pulses after 6 more edges, with no btn_long.
- Bounce on ch1: toggle btn_in[1] every 2 cycles for 20 cycles, then hold high → no activity during bounce; press pulse 6 edges after the final stable change. A 3-cycle glitch while pressed → no release.
- Long-press on ch2: hold btn_in[2] high for 60 cycles → press after edge 6, exactly one btn_long[2] after edge 26, none thereafter. Release → one btn_release.
- Simultaneous channels: press ch0 and ch2 on the same cycle, with ch3 driven low (inverted, so pressed) → btn_press = 4'b1101 on one cycle.
- Reset mid-press: ch0 held with btn_level[0] = 1, assert rst for 1 cycle → outputs cleared with no release pulse. Ch0 still held → new btn_press[0] 6 edges after rst is released.
